// File: rtl/multicycle_ctrl_fsm.sv
// Sequencing control unit for the multicycle ARM-like core.
// Moore FSM over fetch/decode/execute/memory/writeback, plus the
// combinational ALU decoder. PCS, RegW, MemW and FlagW are raw requests;
// condition gating happens downstream.
// Optional build macro: CTRL_ILLEGAL_TRAP_EN (Op 11 locks into TRAP and
// raises Illegal until reset; otherwise Op 11 is a 2-cycle NOP).
module multicycle_ctrl_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  output logic       PCS,
  output logic       RegW,
  output logic       MemW,
  output logic [1:0] FlagW,
  output logic       NextPC,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic       Illegal
);

  // state   | meaning
  // FETCH   | load IR from mem[PC], PC <= PC + 4
  // DECODE  | read register file, ALU forms PC + 8
  // MEMADR  | ALU forms load/store address (base + imm)
  // MEMRD   | read data memory at ALUOut
  // MEMWB   | write loaded data to Rd
  // MEMWR   | write RD2 to data memory at ALUOut
  // EXECR   | data-processing, register operand
  // EXECI   | data-processing, immediate operand
  // ALUWB   | write ALU result to Rd (skipped for CMP / unsupported)
  // BRANCH  | PC <= PC + 8 + offset
  // TRAP    | illegal opcode, parked until reset (trap build only)
`ifdef CTRL_ILLEGAL_TRAP_EN
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_TRAP   = 4'd10
  } state_t;
`else
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;
`endif

  state_t     state;
  state_t     state_nxt;
  logic       alu_op;
  logic       branch;
  logic       reg_w;
  logic [1:0] alu_ctl;
  logic [1:0] flag_w;
  logic       dp_ok;
  logic       no_write;

  // state register; reset drops straight back to FETCH
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // ALU decode from Funct; unsupported encodings leave dp_ok low so the
  // writeback and the flag update are both suppressed
  always_comb begin
    alu_ctl  = 2'b00;
    flag_w   = 2'b00;
    dp_ok    = 1'b0;
    no_write = 1'b0;
    case (Funct[4:1])
      4'b0100: begin alu_ctl = 2'b00; dp_ok = 1'b1; end
      4'b0010: begin alu_ctl = 2'b01; dp_ok = 1'b1; end
      4'b0000: begin alu_ctl = 2'b10; dp_ok = 1'b1; end
      4'b1100: begin alu_ctl = 2'b11; dp_ok = 1'b1; end
      4'b1010: begin
        // CMP is only meaningful with S set
        if (Funct[0]) begin
          alu_ctl  = 2'b01;
          dp_ok    = 1'b1;
          no_write = 1'b1;
        end
      end
      default: ;
    endcase
    if (dp_ok) begin
      flag_w = {Funct[0], Funct[0] & ~alu_ctl[1]};
    end
  end

  // next-state and Moore control outputs
  always_comb begin
    state_nxt = state;
    IRWrite   = 1'b0;
    NextPC    = 1'b0;
    reg_w     = 1'b0;
    MemW      = 1'b0;
    branch    = 1'b0;
    alu_op    = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    case (state)
      S_FETCH: begin
        IRWrite   = 1'b1;
        NextPC    = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        case (Op)
          2'b01:   state_nxt = S_MEMADR;
          2'b00:   state_nxt = Funct[5] ? S_EXECI : S_EXECR;
          2'b10:   state_nxt = S_BRANCH;
`ifdef CTRL_ILLEGAL_TRAP_EN
          default: state_nxt = S_TRAP;
`else
          default: state_nxt = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        ALUSrcB   = 2'b01;
        state_nxt = Funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        AdrSrc    = 1'b1;
        state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        reg_w     = 1'b1;
        state_nxt = S_FETCH;
      end
      S_MEMWR: begin
        AdrSrc    = 1'b1;
        MemW      = 1'b1;
        state_nxt = S_FETCH;
      end
      S_EXECR: begin
        alu_op    = 1'b1;
        state_nxt = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcB   = 2'b01;
        alu_op    = 1'b1;
        state_nxt = S_ALUWB;
      end
      S_ALUWB: begin
        reg_w     = dp_ok & ~no_write;
        state_nxt = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch    = 1'b1;
        state_nxt = S_FETCH;
      end
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_TRAP: begin
        state_nxt = S_TRAP;
      end
`endif
      default: state_nxt = S_FETCH;
    endcase
  end

  // decoder-derived fields; reg_w is only ever set in the writeback
  // states, so the R15 qualifier on PCS is confined to them
  always_comb begin
    ALUControl = alu_op ? alu_ctl : 2'b00;
    FlagW      = alu_op ? flag_w : 2'b00;
    RegW       = reg_w;
    PCS        = branch | (reg_w & (Rd == 4'hF));
    ImmSrc     = Op;
    RegSrc     = {Op == 2'b01, Op == 2'b10};
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  assign Illegal = (state == S_TRAP);
`else
  assign Illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm: walks each instruction class
// and checks the packed control vector in every state.
module tb_multicycle_ctrl_fsm;

  logic       clk;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       PCS, RegW, MemW, NextPC, IRWrite, AdrSrc, ALUSrcA, Illegal;
  logic [1:0] FlagW, ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;
  logic [15:0] ctl;

  int n_checks = 0;
  int n_fail   = 0;

  multicycle_ctrl_fsm dut (
    .clk        (clk),
    .reset      (reset),
    .Op         (Op),
    .Funct      (Funct),
    .Rd         (Rd),
    .PCS        (PCS),
    .RegW       (RegW),
    .MemW       (MemW),
    .FlagW      (FlagW),
    .NextPC     (NextPC),
    .IRWrite    (IRWrite),
    .AdrSrc     (AdrSrc),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUControl (ALUControl),
    .ImmSrc     (ImmSrc),
    .RegSrc     (RegSrc),
    .Illegal    (Illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ctl = {IRWrite, NextPC, PCS, RegW, MemW, AdrSrc, ALUSrcA,
                ALUSrcB, ResultSrc, FlagW, ALUControl, Illegal};

  // pack a hand-written expectation in the same order as ctl
  function automatic logic [15:0] v(input logic irw, input logic npc,
                                    input logic pcs, input logic regw,
                                    input logic memw, input logic adr,
                                    input logic srca, input logic [1:0] srcb,
                                    input logic [1:0] res, input logic [1:0] flg,
                                    input logic [1:0] aluc, input logic ill);
    return {irw, npc, pcs, regw, memw, adr, srca, srcb, res, flg, aluc, ill};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [15:0] V_FETCH, V_DECODE, V_ZERO;

  initial begin
    V_FETCH  = v(1,1,0,0,0,0,1,2'b10,2'b10,2'b00,2'b00,0);
    V_DECODE = v(0,0,0,0,0,0,1,2'b10,2'b10,2'b00,2'b00,0);
    V_ZERO   = 16'h0000;

    reset = 1'b0;
    Op = 2'b00; Funct = 6'b001000; Rd = 4'h1;
    repeat (2) @(negedge clk);
    chk("reset_vec", ctl, V_FETCH);
    chk("reset_immsrc", {14'd0, ImmSrc}, 16'd0);

    // ADD R1,R2,R3
    reset = 1'b1;
    chk("add_fetch", ctl, V_FETCH);
    tick; chk("add_decode", ctl, V_DECODE);
    tick; chk("add_execr", ctl, V_ZERO);
    tick; chk("add_aluwb", ctl, v(0,0,0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,0));
    tick; chk("add_back_fetch", ctl, V_FETCH);

    // SUBS immediate
    Funct = 6'b100101; Rd = 4'h2;
    tick; chk("subs_decode", ctl, V_DECODE);
    tick; chk("subs_execi", ctl, v(0,0,0,0,0,0,0,2'b01,2'b00,2'b11,2'b01,0));
    tick; chk("subs_aluwb", ctl, v(0,0,0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,0));
    tick; chk("subs_fetch", ctl, V_FETCH);

    // CMP register: flags only, no writeback
    Funct = 6'b010101; Rd = 4'h0;
    tick; tick; chk("cmp_execr", ctl, v(0,0,0,0,0,0,0,2'b00,2'b00,2'b11,2'b01,0));
    tick; chk("cmp_aluwb", ctl, V_ZERO);
    tick; chk("cmp_fetch", ctl, V_FETCH);

    // ADD to R15 raises PCS in writeback
    Funct = 6'b001000; Rd = 4'hF;
    tick; tick; tick; chk("addpc_aluwb", ctl, v(0,0,1,1,0,0,0,2'b00,2'b00,2'b00,2'b00,0));
    tick;

    // unsupported DP encoding: no flags, no writeback
    Funct = 6'b000010; Rd = 4'h4;
    tick; tick; chk("unsup_execr", ctl, V_ZERO);
    tick; chk("unsup_aluwb", ctl, V_ZERO);
    tick; chk("unsup_fetch", ctl, V_FETCH);

    // LDR to R15: 5 cycles; IR fields disturbed after MEMADR must not matter
    Op = 2'b01; Funct = 6'b011001; Rd = 4'hF;
    tick; chk("ldr_decode", ctl, V_DECODE);
    tick; chk("ldr_memadr", ctl, v(0,0,0,0,0,0,0,2'b01,2'b00,2'b00,2'b00,0));
    chk("ldr_imm_regsrc", {12'd0, ImmSrc, RegSrc}, 16'b0000_0000_0000_0110);
    tick; chk("ldr_memrd", ctl, v(0,0,0,0,0,1,0,2'b00,2'b00,2'b00,2'b00,0));
    Op = 2'b10; Funct = 6'b000000;
    tick; chk("ldr_memwb", ctl, v(0,0,1,1,0,0,0,2'b00,2'b01,2'b00,2'b00,0));
    tick; chk("ldr_fetch", ctl, V_FETCH);

    // STR: 4 cycles
    Op = 2'b01; Funct = 6'b011000; Rd = 4'h3;
    tick; tick; tick; chk("str_memwr", ctl, v(0,0,0,0,1,1,0,2'b00,2'b00,2'b00,2'b00,0));
    tick; chk("str_fetch", ctl, V_FETCH);

    // B: 3 cycles
    Op = 2'b10; Funct = 6'b000000; Rd = 4'h0;
    tick; chk("b_decode", ctl, V_DECODE);
    tick; chk("b_branch", ctl, v(0,0,1,0,0,0,0,2'b01,2'b10,2'b00,2'b00,0));
    chk("b_imm_regsrc", {12'd0, ImmSrc, RegSrc}, 16'b0000_0000_0000_1001);
    tick; chk("b_fetch", ctl, V_FETCH);

    // reset asserted during MEMWR: MemW must fall with no clock edge
    Op = 2'b01; Funct = 6'b011000; Rd = 4'h3;
    tick; tick; tick; chk("rst_pre_memw", {15'd0, MemW}, 16'd1);
    #1 reset = 1'b0;
    #1 chk("rst_async_memw", {15'd0, MemW}, 16'd0);
    chk("rst_async_vec", ctl, V_FETCH);
    @(negedge clk);
    reset = 1'b1;
    chk("rst_release_fetch", ctl, V_FETCH);

    // Op 11
    Op = 2'b11; Funct = 6'b000000;
    tick; chk("op11_decode", ctl, V_DECODE);
`ifdef CTRL_ILLEGAL_TRAP_EN
    for (int i = 0; i < 12; i++) begin
      tick; chk("op11_trap", ctl, v(0,0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,1));
    end
    reset = 1'b0;
    #1 chk("trap_reset", ctl, V_FETCH);
    @(negedge clk);
    reset = 1'b1;
`else
    tick; chk("op11_fetch", ctl, V_FETCH);
    tick; chk("op11_decode2", ctl, V_DECODE);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
